// File: rtl/data_bus_arbiter.sv
// Four-source round-robin data bus arbiter with beat counting and completion/abort handling.
// Optional forced release on a stalled grant is built when ARB_TIMEOUT_EN is defined.
module data_bus_arbiter #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_mem,
  input  logic       req_sha,
  input  logic       req_aes,
  input  logic       req_ctrl,
  input  logic       data_valid,
  input  logic       data_last,
  input  logic       data_ready,
  output logic       grant_mem,
  output logic       grant_sha,
  output logic       grant_aes,
  output logic       grant_ctrl,
  output logic [1:0] grant_id,
  output logic       bus_busy,
  output logic [7:0] beat_count,
  output logic       xfer_done
`ifdef ARB_TIMEOUT_EN
  ,
  output logic       timeout_err
`endif
);

  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("data_bus_arbiter: TIMEOUT_CYCLES must be in 2..255");
  end

  typedef enum logic {IDLE, GRANT} state_e;

  state_e     state_q, state_d;
  logic [3:0] grant_q, grant_d;
  logic [1:0] last_winner_q, last_winner_d;
  logic [7:0] beat_count_q, beat_count_d;
  logic       xfer_done_q, xfer_done_d;

  logic [3:0] req_vec;
  logic [1:0] cand;
  logic [1:0] winner;
  logic       winner_vld;
  logic       beat;
  logic       owner_req;

`ifdef ARB_TIMEOUT_EN
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);
  logic [7:0] idle_cnt_q, idle_cnt_d;
  logic       timeout_err_q, timeout_err_d;
`endif

  assign req_vec   = {req_ctrl, req_aes, req_sha, req_mem};
  assign beat      = (state_q == GRANT) && data_valid && data_ready;
  // while granted, last_winner is the current owner
  assign owner_req = req_vec[last_winner_q];

  always_comb begin
    winner     = last_winner_q;
    winner_vld = 1'b0;
    cand       = last_winner_q;
    for (int i = 1; i <= 4; i++) begin
      cand = last_winner_q + 2'(i);
      if (!winner_vld && req_vec[cand]) begin
        winner     = cand;
        winner_vld = 1'b1;
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    last_winner_d = last_winner_q;
    beat_count_d  = beat_count_q;
    xfer_done_d   = 1'b0;
`ifdef ARB_TIMEOUT_EN
    idle_cnt_d    = idle_cnt_q;
    timeout_err_d = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (winner_vld) begin
          state_d       = GRANT;
          grant_d       = 4'b0001 << winner;
          last_winner_d = winner;
          beat_count_d  = 8'd0;
`ifdef ARB_TIMEOUT_EN
          idle_cnt_d    = 8'd0;
`endif
        end
      end
      GRANT: begin
        if (beat && beat_count_q != 8'hFF) begin
          beat_count_d = beat_count_q + 8'd1;
        end
`ifdef ARB_TIMEOUT_EN
        idle_cnt_d = beat ? 8'd0 : idle_cnt_q + 8'd1;
`endif
        // completion wins over a same-cycle request drop
        if (beat && data_last) begin
          state_d     = IDLE;
          grant_d     = 4'b0000;
          xfer_done_d = 1'b1;
        end else if (!owner_req) begin
          state_d = IDLE;
          grant_d = 4'b0000;
`ifdef ARB_TIMEOUT_EN
        end else if (!beat && idle_cnt_q == TIMEOUT_LAST) begin
          state_d       = IDLE;
          grant_d       = 4'b0000;
          timeout_err_d = 1'b1;
`endif
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = 4'b0000;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      grant_q       <= 4'b0000;
      last_winner_q <= 2'b11;
      beat_count_q  <= 8'd0;
      xfer_done_q   <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      idle_cnt_q    <= 8'd0;
      timeout_err_q <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      last_winner_q <= last_winner_d;
      beat_count_q  <= beat_count_d;
      xfer_done_q   <= xfer_done_d;
`ifdef ARB_TIMEOUT_EN
      idle_cnt_q    <= idle_cnt_d;
      timeout_err_q <= timeout_err_d;
`endif
    end
  end

  assign grant_mem  = grant_q[0];
  assign grant_sha  = grant_q[1];
  assign grant_aes  = grant_q[2];
  assign grant_ctrl = grant_q[3];
  assign grant_id   = last_winner_q;
  assign bus_busy   = (state_q == GRANT);
  assign beat_count = beat_count_q;
  assign xfer_done  = xfer_done_q;
`ifdef ARB_TIMEOUT_EN
  assign timeout_err = timeout_err_q;
`endif

endmodule

// File: doc/data_bus_arbiter.md
DATA_BUS_ARBITER -- requirements
Module: data_bus_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255: GRANT cycles without an accepted beat before forced release; legal range 2..255.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 req_mem / req_sha / req_aes / req_ctrl  input  1 each  level bus requests; fixed source IDs 00 / 01 / 10 / 11.
REQ-005 data_valid  input  1  beat valid, driven by the granted source.
REQ-006 data_last  input  1  final beat of the transaction; qualified by data_valid.
REQ-007 data_ready  input  1  sink ready.
REQ-008 grant_mem / grant_sha / grant_aes / grant_ctrl  output  1 each  registered grants, one-hot or all zero.
REQ-009 grant_id  output  2  ID of the current grantee; holds the last grantee while idle.
REQ-010 bus_busy  output  1  high while in GRANT.
REQ-011 beat_count  output  8  beats accepted in the current or most recent transaction.
REQ-012 xfer_done  output  1  one-cycle pulse on normal completion.
REQ-013 timeout_err  output  1  one-cycle pulse on forced release; present only with ARB_TIMEOUT_EN.

Function
REQ-014 The block SHALL implement a two-state FSM, IDLE and GRANT, plus a 2-bit last_winner register.
REQ-015 In IDLE with any request asserted, the block SHALL select a winner round-robin, scanning IDs upward from last_winner+1 (mod 4), and enter GRANT on the next edge.
REQ-016 On entry to GRANT, exactly one grant_* bit SHALL rise, grant_id and last_winner SHALL load the winner ID, and beat_count SHALL clear to 0.
REQ-017 Latency: a request sampled in IDLE SHALL be granted on the next cycle.
REQ-018 A beat is accepted in a GRANT cycle with data_valid=1 and data_ready=1.
REQ-019 Each accepted beat SHALL increment beat_count, saturating at 255.
REQ-020 If an accepted beat has data_last=1, the block SHALL return to IDLE on the next edge, dropping all grants and pulsing xfer_done that cycle.
REQ-021 If the grantee's req is low in a GRANT cycle with no accepted last beat, the block SHALL abort to IDLE on the next edge; xfer_done stays 0.
REQ-022 If the last beat and a request drop occur in the same cycle, the block SHALL treat it as normal completion (xfer_done=1).
REQ-023 IDLE SHALL last at least one cycle between grants (bus turnaround), even when requests are pending.
REQ-024 Requests from non-granted sources SHALL be ignored during GRANT; they SHALL NOT preempt the grantee.
REQ-025 With all requests low, the block SHALL remain in IDLE with all grants low.
REQ-026 data_valid, data_ready and data_last SHALL be ignored in IDLE.

Reset
REQ-027 On reset the block SHALL enter IDLE.
REQ-028 Reset values: grants 0, grant_id 2'b11, last_winner 2'b11, bus_busy 0, beat_count 0, xfer_done 0, timeout_err 0, idle counter 0.
REQ-029 With reset values, mem (ID 00) SHALL have first priority after reset.
REQ-030 Reset asserted mid-transaction SHALL drop the grant on the next edge, with no xfer_done or timeout_err pulse.

Configuration
REQ-031 With macro ARB_TIMEOUT_EN defined, the block SHALL include an 8-bit idle counter.
REQ-032 The idle counter SHALL clear on GRANT entry and on every accepted beat, and SHALL increment on each GRANT cycle without a beat.
REQ-033 When the idle counter equals TIMEOUT_CYCLES-1 and no beat is accepted that cycle, the block SHALL go to IDLE on the next edge and pulse timeout_err with the grant drop.
REQ-034 A beat accepted in the threshold cycle SHALL prevent the timeout.
REQ-035 Without ARB_TIMEOUT_EN, there SHALL be no counter and no timeout_err port, and a grant SHALL be held until completion or abort.

Verification
REQ-036 Reset; req_mem=1 at cycle 0 -> grant_mem=1 and grant_id=00 at cycle 1; 3 beats with the last on the third -> beat_count=3, xfer_done pulse, grant_mem=0 on the next cycle.
REQ-037 All four requests held high continuously -> grant order mem, sha, aes, ctrl, mem, with exactly one IDLE cycle between grants.
REQ-038 Grant to sha, then req_sha drops after 1 beat with no last -> IDLE next cycle, xfer_done=0, the next grant goes to aes if requested.
REQ-039 ARB_TIMEOUT_EN, TIMEOUT_CYCLES=4, grant held with data_valid=0 -> timeout_err pulse and grant drop 4 cycles after grant; a beat in the 4th cycle -> no timeout.
REQ-040 rst asserted in the middle of a 5-beat transfer -> all outputs at reset values next cycle, no pulses, first subsequent grant goes to mem when mem and ctrl both request.
